// File: rtl/generate_enaread_seq_pkg.sv
// Shared types and width helpers for the staged read-enable generator.
package enaread_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Width of an index ranging over 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/generate_enaread_seq_if.sv
// Control/status bundle between the solver start logic and the read-enable generator.
interface generate_enaread_seq_if
  import enaread_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int N_PULSES = 2
) ();

  localparam int IDX_W = idx_width(N_PULSES);

  logic                sta;
  logic                abort;
  logic [N_STAGES-1:0] ena_read;
  logic                busy;
  logic                done;
  logic                sta_miss;
  logic [IDX_W-1:0]    pulse_idx;

  modport master (
    output sta, abort,
    input  ena_read, busy, done, sta_miss, pulse_idx
  );

  modport slave (
    input  sta, abort,
    output ena_read, busy, done, sta_miss, pulse_idx
  );

endinterface

// File: rtl/generate_enaread_seq_delay_line.sv
// Single shift register feeding every stage; tap i is din delayed by i*STAGE_DELAY cycles.
module enaread_delay_line #(
  parameter int N_STAGES    = 3,
  parameter int STAGE_DELAY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                din,
  output logic [N_STAGES-1:0] taps
);

  localparam int DEPTH = (N_STAGES - 1) * STAGE_DELAY;

  assign taps[0] = din;

  if (DEPTH > 0) begin : g_shift
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        sr <= '0;
      end else begin
        sr <= (sr << 1) | DEPTH'(din);
      end
    end

    for (genvar i = 1; i < N_STAGES; i++) begin : g_tap
      assign taps[i] = sr[i*STAGE_DELAY-1];
    end
  end

endmodule

// File: rtl/generate_enaread_seq.sv
// Start-triggered read-enable pulse train, fanned out to delayed pipeline stages,
// with busy/done/abort/missed-start signalling. All outputs come straight from flops.
module generate_enaread_seq
  import enaread_pkg::*;
#(
  parameter int PULSE_LEN   = 4,
  parameter int PERIOD      = 12,
  parameter int N_PULSES    = 2,
  parameter int N_STAGES    = 3,
  parameter int STAGE_DELAY = 4
) (
  input logic                 clk,
  input logic                 rst,
  generate_enaread_seq_if.slave bus
);

  if (PULSE_LEN < 1 || PULSE_LEN > PERIOD || PERIOD < 1 || N_PULSES < 1 ||
      N_STAGES < 1 || STAGE_DELAY < 1) begin : g_bad_params
    $fatal(1, "generate_enaread_seq: illegal parameter combination");
  end

  localparam int DRAIN_LEN = (N_STAGES - 1) * STAGE_DELAY;
  localparam int PH_W      = cnt_width(PERIOD);
  localparam int K_W       = cnt_width(N_PULSES);
  localparam int DR_W      = cnt_width(N_STAGES * STAGE_DELAY);
  localparam int IDX_W     = idx_width(N_PULSES);

  localparam logic [PH_W-1:0] PH_LAST      = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_PULSE_END = PH_W'(PULSE_LEN - 1);
  localparam logic [PH_W-1:0] PH_PULSE_LEN = PH_W'(PULSE_LEN);
  localparam logic [K_W-1:0]  K_LAST       = K_W'(N_PULSES - 1);
  localparam logic [DR_W-1:0] DRAIN_INIT   = DR_W'(DRAIN_LEN);

  state_t                state_q, state_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [DR_W-1:0]       drain_q, drain_d;
  logic                  ena0_q, ena0_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  miss_q, miss_d;
  logic                  clr;
  logic [N_STAGES-1:0]   taps;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      k_q     <= '0;
      drain_q <= '0;
      ena0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      ena0_q  <= ena0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      miss_q  <= miss_d;
    end
  end

  // The last pulse ends the run immediately; the rest of its period is not waited out.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    k_d     = k_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    miss_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sta) begin
          state_d = RUN;
          ph_d    = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          miss_d = bus.sta;
          if (k_q == K_LAST && ph_q == PH_PULSE_END) begin
            if (DRAIN_LEN > 0) begin
              state_d = DRAIN;
              drain_d = DRAIN_INIT;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (ph_q == PH_LAST) begin
            ph_d = '0;
            k_d  = k_q + K_W'(1);
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          miss_d = bus.sta;
          if (drain_q == DR_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q - DR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ena0_d = (state_d == RUN) && (ph_d < PH_PULSE_LEN);
    busy_d = (state_d != IDLE);
  end

  enaread_delay_line #(
    .N_STAGES    (N_STAGES),
    .STAGE_DELAY (STAGE_DELAY)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .din  (ena0_q),
    .taps (taps)
  );

  assign bus.ena_read  = taps;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sta_miss  = miss_q;
  assign bus.pulse_idx = k_q[IDX_W-1:0];

endmodule

// File: tb/tb_generate_enaread_seq.sv
// Scoreboarded bench for generate_enaread_seq: default-parameter scenarios plus two parameter corners.
module tb_generate_enaread_seq;
  import enaread_pkg::*;

  localparam int PL        = 4;
  localparam int P         = 12;
  localparam int NP        = 2;
  localparam int NS        = 3;
  localparam int SD        = 4;
  localparam int DRAIN_LEN = (NS - 1) * SD;
  localparam int RUN_END   = (NP - 1) * P + PL;
  localparam int BUSY_END  = RUN_END + DRAIN_LEN;
  localparam int NEVER     = 1 << 30;
  localparam int MAXC      = 72;
  localparam int NSCEN     = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  generate_enaread_seq_if #(.N_STAGES(NS), .N_PULSES(NP)) bus ();
  generate_enaread_seq #(
    .PULSE_LEN(PL), .PERIOD(P), .N_PULSES(NP), .N_STAGES(NS), .STAGE_DELAY(SD)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  generate_enaread_seq_if #(.N_STAGES(1), .N_PULSES(1)) bus_a ();
  generate_enaread_seq #(
    .PULSE_LEN(3), .PERIOD(3), .N_PULSES(1), .N_STAGES(1), .STAGE_DELAY(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  generate_enaread_seq_if #(.N_STAGES(3), .N_PULSES(3)) bus_b ();
  generate_enaread_seq #(
    .PULSE_LEN(4), .PERIOD(4), .N_PULSES(3), .N_STAGES(3), .STAGE_DELAY(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [NS-1:0] ena;
    logic          busy;
    logic          done;
    logic          miss;
    int            idx;
  } exp_t;

  typedef struct {
    int sta_a;
    int sta_b;
    int abort_c;
    int rst_c;
    int len;
  } scen_t;

  typedef struct {
    int            scen;
    int            cyc;
    logic [NS-1:0] ena;
    logic          busy;
    logic          done;
    logic          miss;
  } spot_t;

  exp_t  sbq[$];
  scen_t scens[NSCEN];
  spot_t spots[$];

  logic [NS-1:0] tr_ena  [NSCEN][MAXC];
  logic          tr_busy [NSCEN][MAXC];
  logic          tr_done [NSCEN][MAXC];
  logic          tr_miss [NSCEN][MAXC];

  int n_cmp = 0;
  int n_bad = 0;

  bit m_have;
  int m_t;
  int m_cut;
  int m_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a);
    rst       = r;
    bus.sta   = s;
    bus.abort = a;
  endtask

  // r = cycles since the edge that accepted the start
  function automatic bit in_pulse(input int r);
    int q;
    if (r < 1) return 1'b0;
    q = r - 1;
    return (q / P < NP) && (q % P < PL);
  endfunction

  function automatic bit model_busy(input int c);
    return m_have && c > m_t && c <= m_t + BUSY_END && c <= m_cut;
  endfunction

  // Consumes the inputs sampled at cycle c and predicts the outputs of cycle c+1.
  function automatic exp_t model_step(input int c, input bit r, input bit s, input bit a);
    exp_t e;
    int   n;
    e.miss = 1'b0;
    if (r) begin
      m_have = 1'b0;
      m_idx  = 0;
    end else if (model_busy(c)) begin
      if (a) m_cut = c;
      else if (s) e.miss = 1'b1;
    end else if (s) begin
      m_have = 1'b1;
      m_t    = c;
      m_cut  = NEVER;
    end
    n = c + 1;
    for (int i = 0; i < NS; i++)
      e.ena[i] = m_have && n <= m_cut && in_pulse(n - m_t - i * SD);
    e.busy = model_busy(n);
    e.done = m_have && m_cut == NEVER && n == m_t + BUSY_END + 1;
    if (m_have && n <= m_cut && n > m_t && n <= m_t + RUN_END)
      m_idx = (n - 1 - m_t) / P;
    e.idx = m_idx;
    return e;
  endfunction

  task automatic runScenario(input int si);
    scen_t sc;
    exp_t  e;
    sc = scens[si];
    sbq.delete();
    for (int c = 0; c <= sc.len; c++) begin
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        tr_ena[si][c]  = bus.ena_read;
        tr_busy[si][c] = bus.busy;
        tr_done[si][c] = bus.done;
        tr_miss[si][c] = bus.sta_miss;
        checkOutput($sformatf("s%0d ena_read", si), c, int'(bus.ena_read), int'(e.ena));
        checkOutput($sformatf("s%0d busy", si), c, int'(bus.busy), int'(e.busy));
        checkOutput($sformatf("s%0d done", si), c, int'(bus.done), int'(e.done));
        checkOutput($sformatf("s%0d sta_miss", si), c, int'(bus.sta_miss), int'(e.miss));
        checkOutput($sformatf("s%0d pulse_idx", si), c, int'(bus.pulse_idx), e.idx);
      end
      if (c < sc.len) begin
        applyStimulus(c == 0 || c == sc.rst_c, c == sc.sta_a || c == sc.sta_b, c == sc.abort_c);
        sbq.push_back(model_step(c, rst, bus.sta, bus.abort));
        tick();
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runCornerA();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin
        checkOutput("a ena_read0", c, int'(bus_a.ena_read[0]), int'(c >= 6 && c <= 8));
        checkOutput("a busy", c, int'(bus_a.busy), int'(c >= 6 && c <= 8));
        checkOutput("a done", c, int'(bus_a.done), int'(c == 9));
      end
      rst         = (c == 0);
      bus_a.sta   = (c == 5);
      bus_a.abort = 1'b0;
      tick();
    end
  endtask

  task automatic runCornerB();
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin
        checkOutput("b ena_read0", c, int'(bus_b.ena_read[0]), int'(c >= 6 && c <= 17));
        checkOutput("b ena_read2", c, int'(bus_b.ena_read[2]), int'(c >= 14 && c <= 25));
        checkOutput("b busy", c, int'(bus_b.busy), int'(c >= 6 && c <= 25));
        checkOutput("b done", c, int'(bus_b.done), int'(c == 26));
      end
      rst         = (c == 0);
      bus_b.sta   = (c == 5);
      bus_b.abort = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.sta     = 1'b0;
    bus.abort   = 1'b0;
    bus_a.sta   = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.sta   = 1'b0;
    bus_b.abort = 1'b0;
    m_have      = 1'b0;
    m_t         = 0;
    m_cut       = NEVER;
    m_idx       = 0;

    scens[0] = '{sta_a: 10, sta_b: -1, abort_c: -1, rst_c: -1, len: 45};
    scens[1] = '{sta_a: 10, sta_b: 35, abort_c: -1, rst_c: -1, len: 64};
    scens[2] = '{sta_a: 10, sta_b: 20, abort_c: -1, rst_c: -1, len: 45};
    scens[3] = '{sta_a: 10, sta_b: 20, abort_c: 16, rst_c: -1, len: 50};
    scens[4] = '{sta_a: 10, sta_b: -1, abort_c: -1, rst_c: 25, len: 45};
    scens[5] = '{sta_a: 10, sta_b: -1, abort_c: -1, rst_c: -1, len: 45};

    spots.push_back('{0,  1, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{0, 11, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 14, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 15, 3'b010, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 19, 3'b100, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 23, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 27, 3'b010, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 31, 3'b100, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 34, 3'b100, 1'b1, 1'b0, 1'b0});
    spots.push_back('{0, 35, 3'b000, 1'b0, 1'b1, 1'b0});
    spots.push_back('{0, 36, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{1, 35, 3'b000, 1'b0, 1'b1, 1'b0});
    spots.push_back('{1, 36, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{1, 39, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{1, 40, 3'b010, 1'b1, 1'b0, 1'b0});
    spots.push_back('{1, 60, 3'b000, 1'b0, 1'b1, 1'b0});
    spots.push_back('{2, 21, 3'b100, 1'b1, 1'b0, 1'b1});
    spots.push_back('{2, 22, 3'b100, 1'b1, 1'b0, 1'b0});
    spots.push_back('{2, 35, 3'b000, 1'b0, 1'b1, 1'b0});
    spots.push_back('{3, 16, 3'b010, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3, 17, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{3, 20, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{3, 21, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3, 24, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3, 25, 3'b010, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3, 35, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3, 45, 3'b000, 1'b0, 1'b1, 1'b0});
    spots.push_back('{4, 25, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{4, 26, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{4, 35, 3'b000, 1'b0, 1'b0, 1'b0});
    spots.push_back('{5, 11, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{5, 23, 3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{5, 35, 3'b000, 1'b0, 1'b1, 1'b0});

    for (int si = 0; si < NSCEN; si++) begin
      $display("[TB] scenario %0d", si);
      runScenario(si);
    end

    foreach (spots[j]) begin
      checkOutput($sformatf("spot s%0d ena_read", spots[j].scen), spots[j].cyc,
                  int'(tr_ena[spots[j].scen][spots[j].cyc]), int'(spots[j].ena));
      checkOutput($sformatf("spot s%0d busy", spots[j].scen), spots[j].cyc,
                  int'(tr_busy[spots[j].scen][spots[j].cyc]), int'(spots[j].busy));
      checkOutput($sformatf("spot s%0d done", spots[j].scen), spots[j].cyc,
                  int'(tr_done[spots[j].scen][spots[j].cyc]), int'(spots[j].done));
      checkOutput($sformatf("spot s%0d sta_miss", spots[j].scen), spots[j].cyc,
                  int'(tr_miss[spots[j].scen][spots[j].cyc]), int'(spots[j].miss));
    end

    $display("[TB] corner: single stage, single pulse, PULSE_LEN=PERIOD=3");
    runCornerA();
    $display("[TB] corner: three back-to-back pulses, PULSE_LEN=PERIOD=4");
    runCornerB();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
